div_issue_sched: RTL and testbench
==================================

Name: div_issue_sched

Overview:
- Shares one divider between NUM_REQ requesters (e.g. integer pipe, vector/FP helper).
- Round-robin arbitrates the requests and enqueues the winner into the div FIFO, which is an external cva5_fifo-style instance.
- Sequences the divider: pop, start, wait for done, hold the result until the writeback handshake completes.
- Bypasses the divider for divide-by-zero.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- XLEN, 32, operand width.
- ID_W, 3, requester-local tag width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  request valid per requester
- req_ready  out  NUM_REQ  request accepted this cycle
- req_dividend  in  NUM_REQ*XLEN  packed dividends
- req_divisor  in  NUM_REQ*XLEN  packed divisors
- req_signed  in  NUM_REQ  signed-op flag
- req_id  in  NUM_REQ*ID_W  packed tags
- fifo_push  out  1  enqueue into div FIFO
- fifo_potential_push  out  1  data-write enable; equals fifo_push
- fifo_data_in  out  ENTRY_W  packed entry
- fifo_full  in  1  FIFO full
- fifo_valid  in  1  FIFO non-empty
- fifo_data_out  in  ENTRY_W  head entry
- fifo_pop  out  1  dequeue head
- div_start  out  1  one-cycle divider start pulse
- div_dividend, div_divisor  out  XLEN  registered operands
- div_signed  out  1  registered signed flag
- div_done  in  1  divider result valid (one cycle)
- div_quotient, div_remainder  in  XLEN  divider results
- wb_valid  out  1  result valid
- wb_src  out  SRC_W  originating requester
- wb_id  out  ID_W  tag
- wb_quotient, wb_remainder  out  XLEN  results
- wb_ack  in  1  result consumed

Behaviour:
- Widths: SRC_W = $clog2(NUM_REQ). ENTRY_W = SRC_W+ID_W+1+2*XLEN. Field order MSB to LSB: src, id, signed, dividend, divisor.
- Reset (rst=0, asynchronous): FSM=IDLE, rr_ptr=0, all outputs 0, result registers 0.
- Arbitration is combinational. The grant is the first valid requester at or after rr_ptr, wrapping.
- can_push = ~fifo_full | fifo_pop. The FIFO tolerates push+pop in the same cycle when full.
- fifo_push = |req_valid & can_push. req_ready = grant & {NUM_REQ{fifo_push}}; at most one bit set.
- On fifo_push, rr_ptr <= granted index + 1, wrapping to 0 after NUM_REQ-1. Otherwise rr_ptr holds.
- FSM states and transitions:
  - IDLE: if fifo_valid, assert fifo_pop and latch the entry. If divisor==0 go to WB with quotient = all ones and remainder = dividend (the RISC-V rule applies for both signed and unsigned). Else go to START.
  - START: div_start=1 for exactly one cycle, operands held from the latch. Go to BUSY.
  - BUSY: wait for div_done. On div_done, latch quotient/remainder and go to WB. Any div_done outside BUSY is ignored.
  - WB: wb_valid=1; the wb_* fields are stable until wb_ack. On wb_ack with fifo_valid, pop and latch the next entry in the same cycle, then go to START (or stay in WB on divisor==0). On wb_ack without fifo_valid, go to IDLE.
- Latency with the FIFO holding an entry and IDLE: pop at cycle 0, div_start at cycle 1, wb_valid on the cycle after div_done. Div-by-zero: wb_valid at cycle 1.
- fifo_pop is only asserted when fifo_valid=1. It is asserted only in IDLE or in WB with wb_ack.
- Signed overflow (most-negative / -1) is the divider's responsibility and is not special-cased here.
- Reset mid-operation: the FIFO shares rst and is flushed. Any in-flight divider result is discarded because the FSM returns to IDLE.

Decomposition:
- Shared package div_sched_pkg holds:
  - the div_entry_t packed struct (src, id, signed, dividend, divisor);
  - the state enum {IDLE, START, BUSY, WB};
  - ENTRY_W and SRC_W localparams.
- One sub-module: rr_arbiter (NUM_REQ parameter; inputs req, advance; output one-hot grant and encoded index; owns rr_ptr).

Test Plan:
- After reset, req_valid=2'b11 with fifo empty. Expect grants in order req0, req1, req0, req1 on consecutive cycles; rr_ptr alternates 1, 0.
- FIFO full, fifo_pop=0, req_valid=2'b01. Expect fifo_push=0 and req_ready=0. Then assert fifo_pop for one cycle: expect fifo_push=1 and req_ready=2'b01 in that cycle.
- Unsigned 100/7, divider done 4 cycles after start. Expect div_start 1 cycle after pop, wb_valid with quotient 14, remainder 2, and the correct src/id; wb_valid held 3 cycles while wb_ack=0.
- Divisor=0, dividend=0x1234. Expect no div_start; wb_valid 1 cycle after pop with quotient 0xFFFFFFFF and remainder 0x1234.
- Two queued ops with wb_ack asserted on the first wb_valid cycle. Expect fifo_pop in the same cycle as the ack and div_start on the next cycle (no IDLE bubble).
- Assert rst=0 asynchronously during BUSY, then release. Expect all outputs 0 immediately; a stale div_done after release produces no wb_valid.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared types and default widths for the divider issue scheduler.
package div_sched_pkg;

  localparam int unsigned NUM_REQ_DEF = 2;
  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned ID_W_DEF    = 3;

  localparam int unsigned SRC_W   = $clog2(NUM_REQ_DEF);
  localparam int unsigned ENTRY_W = SRC_W + ID_W_DEF + 1 + 2 * XLEN_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    WB    = 2'd3
  } div_state_e;

  // FIFO entry layout at the default widths, MSB first.
  typedef struct packed {
    logic [SRC_W-1:0]    src;
    logic [ID_W_DEF-1:0] id;
    logic                sgn;
    logic [XLEN_DEF-1:0] dividend;
    logic [XLEN_DEF-1:0] divisor;
  } div_entry_t;

endpackage

// File: rtl/div_issue_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the
// pointer, wrapping; the pointer moves past the winner only when advanced.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_advance,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx
);

  localparam int unsigned S_W = $clog2(NUM_REQ);

  logic [S_W-1:0]     r_ptr;
  logic [S_W-1:0]     w_idx;
  logic               w_found;
  logic [NUM_REQ-1:0] w_grant;

  // Search from the pointer upward, wrapping, for the first valid request.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int unsigned k;
      k = (32'(r_ptr) + 32'(i)) % NUM_REQ;
      if (!w_found && i_req[k]) begin
        w_found = 1'b1;
        w_idx   = S_W'(k);
      end
    end
  end

  // One-hot grant derived from the encoded winner.
  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_idx] = 1'b1;
  end

  // Pointer moves to the slot after the winner when its request is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (w_idx == S_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;

endmodule

// File: rtl/div_issue_sched.sv
// Shares one divider between several requesters: arbitrates into an external
// FIFO, then pops, starts the divider, and holds the result for writeback.
//
// state | meaning
// IDLE  | nothing in flight; pop the FIFO head as soon as one is present
// START | one-cycle divider start pulse with latched operands
// BUSY  | waiting for div_done
// WB    | result presented on wb_*; stable until wb_ack
module div_issue_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned ID_W    = ID_W_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*XLEN-1:0]                req_dividend,
  input  logic [NUM_REQ*XLEN-1:0]                req_divisor,
  input  logic [NUM_REQ-1:0]                     req_signed,
  input  logic [NUM_REQ*ID_W-1:0]                req_id,
  output logic                                   fifo_push,
  output logic                                   fifo_potential_push,
  output logic [$clog2(NUM_REQ)+ID_W+2*XLEN:0]   fifo_data_in,
  input  logic                                   fifo_full,
  input  logic                                   fifo_valid,
  input  logic [$clog2(NUM_REQ)+ID_W+2*XLEN:0]   fifo_data_out,
  output logic                                   fifo_pop,
  output logic                                   div_start,
  output logic [XLEN-1:0]                        div_dividend,
  output logic [XLEN-1:0]                        div_divisor,
  output logic                                   div_signed,
  input  logic                                   div_done,
  input  logic [XLEN-1:0]                        div_quotient,
  input  logic [XLEN-1:0]                        div_remainder,
  output logic                                   wb_valid,
  output logic [$clog2(NUM_REQ)-1:0]             wb_src,
  output logic [ID_W-1:0]                        wb_id,
  output logic [XLEN-1:0]                        wb_quotient,
  output logic [XLEN-1:0]                        wb_remainder,
  input  logic                                   wb_ack
);

  localparam int unsigned S_W = $clog2(NUM_REQ);
  localparam int unsigned E_W = S_W + ID_W + 1 + 2 * XLEN;

  logic [NUM_REQ-1:0] w_grant;
  logic [S_W-1:0]     w_gidx;
  logic               w_can_push;
  logic               w_push;

  logic [S_W-1:0]     w_h_src;
  logic [ID_W-1:0]    w_h_id;
  logic               w_h_sgn;
  logic [XLEN-1:0]    w_h_dividend;
  logic [XLEN-1:0]    w_h_divisor;
  logic               w_h_dz;

  div_state_e         r_state;
  div_state_e         w_next;
  logic               w_pop;
  logic               w_start;
  logic               w_wbv;

  logic [S_W-1:0]     r_src;
  logic [ID_W-1:0]    r_id;
  logic               r_sgn;
  logic [XLEN-1:0]    r_dividend;
  logic [XLEN-1:0]    r_divisor;
  logic [XLEN-1:0]    r_quot;
  logic [XLEN-1:0]    r_rem;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_req     (req_valid),
    .i_advance (w_push),
    .o_grant   (w_grant),
    .o_idx     (w_gidx)
  );

  // A full FIFO can still accept a push in the cycle its head is popped.
  assign w_can_push          = ~fifo_full | w_pop;
  assign w_push              = (|req_valid) & w_can_push;
  assign fifo_push           = w_push;
  assign fifo_potential_push = w_push;
  assign req_ready           = w_grant & {NUM_REQ{w_push}};
  assign fifo_data_in        = w_push ? {w_gidx,
                                         req_id[w_gidx*ID_W +: ID_W],
                                         req_signed[w_gidx],
                                         req_dividend[w_gidx*XLEN +: XLEN],
                                         req_divisor[w_gidx*XLEN +: XLEN]}
                                      : '0;

  assign w_h_src      = fifo_data_out[E_W-1 -: S_W];
  assign w_h_id       = fifo_data_out[E_W-S_W-1 -: ID_W];
  assign w_h_sgn      = fifo_data_out[2*XLEN];
  assign w_h_dividend = fifo_data_out[2*XLEN-1 -: XLEN];
  assign w_h_divisor  = fifo_data_out[XLEN-1:0];
  assign w_h_dz       = (w_h_divisor == '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state and control outputs; divide-by-zero skips the divider.
  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_start = 1'b0;
    w_wbv   = 1'b0;
    case (r_state)
      IDLE: begin
        if (fifo_valid) begin
          w_pop  = 1'b1;
          w_next = w_h_dz ? WB : START;
        end
      end
      START: begin
        w_start = 1'b1;
        w_next  = BUSY;
      end
      BUSY: begin
        if (div_done) w_next = WB;
      end
      WB: begin
        w_wbv = 1'b1;
        if (wb_ack) begin
          if (fifo_valid) begin
            w_pop  = 1'b1;
            w_next = w_h_dz ? WB : START;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch the popped entry and capture results (zero-divisor result follows RISC-V).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src      <= '0;
      r_id       <= '0;
      r_sgn      <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
    end else if (w_pop) begin
      r_src      <= w_h_src;
      r_id       <= w_h_id;
      r_sgn      <= w_h_sgn;
      r_dividend <= w_h_dividend;
      r_divisor  <= w_h_divisor;
      if (w_h_dz) begin
        r_quot <= '1;
        r_rem  <= w_h_dividend;
      end
    end else if (r_state == BUSY && div_done) begin
      r_quot <= div_quotient;
      r_rem  <= div_remainder;
    end
  end

  assign fifo_pop     = w_pop;
  assign div_start    = w_start;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign div_signed   = r_sgn;
  assign wb_valid     = w_wbv;
  assign wb_src       = r_src;
  assign wb_id        = r_id;
  assign wb_quotient  = r_quot;
  assign wb_remainder = r_rem;

endmodule

// File: tb/tb_div_issue_sched.sv
// Directed bench for div_issue_sched with a behavioural divider and a
// scoreboard of expected writebacks.
module tb_div_issue_sched;
  import div_sched_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          req_valid = '0;
  logic [1:0]          req_ready;
  logic [63:0]         req_dividend = '0;
  logic [63:0]         req_divisor = '0;
  logic [1:0]          req_signed = '0;
  logic [5:0]          req_id = '0;
  logic                fifo_push;
  logic                fifo_potential_push;
  logic [ENTRY_W-1:0]  fifo_data_in;
  logic                fifo_full = 1'b0;
  logic                fifo_valid = 1'b0;
  logic [ENTRY_W-1:0]  fifo_data_out = '0;
  logic                fifo_pop;
  logic                div_start;
  logic [31:0]         div_dividend;
  logic [31:0]         div_divisor;
  logic                div_signed;
  logic                div_done;
  logic [31:0]         div_quotient;
  logic [31:0]         div_remainder;
  logic                wb_valid;
  logic [0:0]          wb_src;
  logic [2:0]          wb_id;
  logic [31:0]         wb_quotient;
  logic [31:0]         wb_remainder;
  logic                wb_ack = 1'b0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [0:0]  src;
    logic [2:0]  id;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  div_issue_sched u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_dividend        (req_dividend),
    .req_divisor         (req_divisor),
    .req_signed          (req_signed),
    .req_id              (req_id),
    .fifo_push           (fifo_push),
    .fifo_potential_push (fifo_potential_push),
    .fifo_data_in        (fifo_data_in),
    .fifo_full           (fifo_full),
    .fifo_valid          (fifo_valid),
    .fifo_data_out       (fifo_data_out),
    .fifo_pop            (fifo_pop),
    .div_start           (div_start),
    .div_dividend        (div_dividend),
    .div_divisor         (div_divisor),
    .div_signed          (div_signed),
    .div_done            (div_done),
    .div_quotient        (div_quotient),
    .div_remainder       (div_remainder),
    .wb_valid            (wb_valid),
    .wb_src              (wb_src),
    .wb_id               (wb_id),
    .wb_quotient         (wb_quotient),
    .wb_remainder        (wb_remainder),
    .wb_ack              (wb_ack)
  );

  // Behavioural divider: done pulses 4 cycles after the start cycle.
  int unsigned div_cnt = 0;
  logic [31:0] m_dvd = '0;
  logic [31:0] m_dvs = '0;
  always @(posedge clk) begin
    if (div_start) begin
      div_cnt <= 4;
      m_dvd   <= div_dividend;
      m_dvs   <= div_divisor;
    end else if (div_cnt != 0) begin
      div_cnt <= div_cnt - 1;
    end
  end
  assign div_done      = (div_cnt == 1);
  assign div_quotient  = (m_dvs != 0) ? m_dvd / m_dvs : '1;
  assign div_remainder = (m_dvs != 0) ? m_dvd % m_dvs : m_dvd;

  function automatic div_entry_t mk(input logic s, input logic [2:0] id,
                                    input logic sg, input logic [31:0] a,
                                    input logic [31:0] b);
    div_entry_t e;
    e.src = s; e.id = id; e.sgn = sg; e.dividend = a; e.divisor = b;
    return e;
  endfunction

  function automatic exp_t ex(input div_entry_t e);
    exp_t x;
    x.q   = (e.divisor == 0) ? 32'hFFFF_FFFF : e.dividend / e.divisor;
    x.r   = (e.divisor == 0) ? e.dividend : e.dividend % e.divisor;
    x.src = e.src;
    x.id  = e.id;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Compare wb_* against the scoreboard head; pop it when it is consumed.
  task automatic chk_wb(input string tag, input bit consume);
    chk({tag, "_valid"}, wb_valid, 1'b1);
    if (sb.size() == 0) begin
      n_chk++;
      $error("FAIL %s_sb: got empty scoreboard expected an entry", tag);
    end else begin
      chk({tag, "_q"},   wb_quotient,  sb[0].q);
      chk({tag, "_r"},   wb_remainder, sb[0].r);
      chk({tag, "_src"}, wb_src,       sb[0].src);
      chk({tag, "_id"},  wb_id,        sb[0].id);
      if (consume) void'(sb.pop_front());
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    div_entry_t e0, e1, e;
    exp_t       x;

    // Reset state.
    cyc(); cyc();
    #1;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_div_start", div_start, 1'b0);
    chk("rst_fifo_push", fifo_push, 1'b0);
    chk("rst_div_dividend", div_dividend, 32'd0);
    chk("rst_wb_quot", wb_quotient, 32'd0);
    chk("rst_ptr", u_dut.u_arb.r_ptr, 1'b0);
    cyc(); rst = 1'b1;

    // Round-robin with both requesters active, FIFO empty.
    e0 = mk(1'b0, 3'd2, 1'b0, 32'd10, 32'd20);
    e1 = mk(1'b1, 3'd4, 1'b1, 32'd11, 32'd21);
    req_id       = {3'd4, 3'd2};
    req_dividend = {32'd11, 32'd10};
    req_divisor  = {32'd21, 32'd20};
    req_signed   = 2'b10;
    for (int k = 0; k < 4; k++) begin
      cyc();
      req_valid = 2'b11;
      #1;
      chk("rr_ptr", u_dut.u_arb.r_ptr, (k % 2 == 0) ? 1'b0 : 1'b1);
      chk("rr_push", fifo_push, 1'b1);
      chk("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_data", fifo_data_in, (k % 2 == 0) ? e0 : e1);
    end

    // FIFO full blocks the push until a pop frees a slot.
    cyc();
    req_valid = 2'b01; fifo_full = 1'b1; fifo_valid = 1'b0;
    #1;
    chk("rr_ptr_wrap", u_dut.u_arb.r_ptr, 1'b0);
    chk("full_push", fifo_push, 1'b0);
    chk("full_ready", req_ready, 2'b00);
    chk("full_pop", fifo_pop, 1'b0);

    // Unsigned 100/7: pop with push in the same cycle.
    e = mk(1'b1, 3'd5, 1'b0, 32'd100, 32'd7);
    cyc();
    fifo_valid = 1'b1; fifo_data_out = e; sb.push_back(ex(e));
    #1;
    chk("full_pop_now", fifo_pop, 1'b1);
    chk("full_push_now", fifo_push, 1'b1);
    chk("full_ready_now", req_ready, 2'b01);
    cyc();
    fifo_valid = 1'b0; fifo_full = 1'b0; req_valid = 2'b00;
    #1;
    chk("u_start", div_start, 1'b1);
    chk("u_dvd", div_dividend, 32'd100);
    chk("u_dvs", div_divisor, 32'd7);
    chk("u_sgn", div_signed, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      chk("u_busy_start", div_start, 1'b0);
      chk("u_busy_wbv", wb_valid, 1'b0);
    end
    cyc(); #1;
    chk_wb("u_wb0", 1'b0);
    cyc(); #1;
    chk_wb("u_wb1", 1'b0);
    cyc();
    wb_ack = 1'b1;
    #1;
    chk_wb("u_wb2", 1'b1);
    chk("u_ack_pop", fifo_pop, 1'b0);
    cyc();
    wb_ack = 1'b0;
    #1;
    chk("u_idle_wbv", wb_valid, 1'b0);

    // Divide by zero bypasses the divider.
    e = mk(1'b0, 3'd3, 1'b1, 32'h1234, 32'd0);
    cyc();
    fifo_valid = 1'b1; fifo_data_out = e; sb.push_back(ex(e));
    #1;
    chk("dz_pop", fifo_pop, 1'b1);
    cyc();
    fifo_valid = 1'b0; wb_ack = 1'b1;
    #1;
    chk("dz_start", div_start, 1'b0);
    chk_wb("dz_wb", 1'b1);
    cyc();
    wb_ack = 1'b0;
    #1;
    chk("dz_idle_wbv", wb_valid, 1'b0);
    chk("dz_idle_start", div_start, 1'b0);

    // Back-to-back ops: ack and pop in the same cycle, no IDLE bubble.
    e0 = mk(1'b1, 3'd1, 1'b0, 32'd200, 32'd9);
    e1 = mk(1'b0, 3'd6, 1'b0, 32'd50, 32'd5);
    cyc();
    fifo_valid = 1'b1; fifo_data_out = e0; sb.push_back(ex(e0));
    #1;
    chk("b2b_pop0", fifo_pop, 1'b1);
    cyc();
    fifo_data_out = e1; sb.push_back(ex(e1));
    #1;
    chk("b2b_start0", div_start, 1'b1);
    chk("b2b_dvd0", div_dividend, 32'd200);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      chk("b2b_busy_pop", fifo_pop, 1'b0);
      chk("b2b_busy_wbv", wb_valid, 1'b0);
    end
    cyc();
    wb_ack = 1'b1;
    #1;
    chk("b2b_ack_pop", fifo_pop, 1'b1);
    chk_wb("b2b_wb0", 1'b1);
    cyc();
    wb_ack = 1'b0; fifo_valid = 1'b0;
    #1;
    chk("b2b_start1", div_start, 1'b1);
    chk("b2b_dvd1", div_dividend, 32'd50);
    chk("b2b_wbv_gap", wb_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      chk("b2b_busy1_wbv", wb_valid, 1'b0);
    end
    cyc();
    wb_ack = 1'b1;
    #1;
    chk_wb("b2b_wb1", 1'b1);
    cyc();
    wb_ack = 1'b0;
    #1;
    chk("b2b_idle_wbv", wb_valid, 1'b0);

    // Asynchronous reset during BUSY discards the in-flight result.
    e = mk(1'b1, 3'd2, 1'b0, 32'd77, 32'd3);
    cyc();
    fifo_valid = 1'b1; fifo_data_out = e;
    #1;
    chk("ar_pop", fifo_pop, 1'b1);
    cyc();
    fifo_valid = 1'b0;
    #1;
    chk("ar_start", div_start, 1'b1);
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk("ar_state", u_dut.r_state, IDLE);
    chk("ar_wbv", wb_valid, 1'b0);
    chk("ar_start_0", div_start, 1'b0);
    chk("ar_dvd", div_dividend, 32'd0);
    chk("ar_dvs", div_divisor, 32'd0);
    chk("ar_wb_id", wb_id, 3'd0);
    chk("ar_pop_0", fifo_pop, 1'b0);
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(); #1;
      chk("ar_stale_wbv", wb_valid, 1'b0);
      chk("ar_stale_start", div_start, 1'b0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
